// File: rtl/alu_pool_arbiter_if.sv
// Request/grant bundle between issuing SICs and the pooled-ALU lock arbiter.
// The owner-return pulse is named alu_release because "release" is a reserved word.
interface alu_pool_arbiter_if #(
  parameter int unsigned NUM_ALUS  = 4,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ID_WIDTH  = 16
);
  // A single-ALU pool still carries a 1-bit index so the bus never has zero width
  localparam int unsigned ALU_IDX_W = (NUM_ALUS > 1) ? $clog2(NUM_ALUS) : 1;

  logic [NUM_PORTS-1:0]                req_valid;
  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]  req_id;
  logic [NUM_PORTS-1:0]                alu_release;
  logic                                flush;
  logic [NUM_PORTS-1:0]                grant;
  logic [NUM_PORTS-1:0][ALU_IDX_W-1:0] grant_alu;
  logic [NUM_ALUS-1:0]                 alu_busy;
  logic [NUM_ALUS-1:0][ID_WIDTH-1:0]   owner_id;

  modport master (
    output req_valid, req_id, alu_release, flush,
    input  grant, grant_alu, alu_busy, owner_id
  );

  modport slave (
    input  req_valid, req_id, alu_release, flush,
    output grant, grant_alu, alu_busy, owner_id
  );
endinterface

// File: rtl/alu_pool_arbiter.sv
// Locks pooled ALUs to requesting SIC ports, one ALU per port, with registered grants.
// Ranking is round-robin by default; define ALU_ARB_AGE_PRIORITY_EN for oldest-issue-ID-first.
module alu_pool_arbiter #(
  parameter int unsigned NUM_ALUS  = 4,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ID_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_pool_arbiter_if.slave bus
);

  localparam int unsigned ALU_IDX_W  = (NUM_ALUS > 1) ? $clog2(NUM_ALUS) : 1;
  localparam int unsigned PORT_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OWN  = 2'd2
  } port_state_e;

  port_state_e                         state_q [NUM_PORTS];
  port_state_e                         state_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]                grant_q, grant_d;
  logic [NUM_PORTS-1:0][ALU_IDX_W-1:0] grant_alu_q, grant_alu_d;
  logic [NUM_ALUS-1:0]                 busy_q, busy_d;
  logic [NUM_ALUS-1:0][ID_WIDTH-1:0]   owner_q, owner_d;

  logic [NUM_PORTS-1:0] elig;
  logic [NUM_ALUS-1:0]  free_mask;
  logic                 found;
  logic                 alu_found;
  int                   cand;
  int                   alu_sel;

`ifdef ALU_ARB_AGE_PRIORITY_EN
  logic [NUM_PORTS-1:0] picked;

  // a is older than b when (a - b) wraps negative in ID_WIDTH arithmetic
  function automatic logic is_older(input logic [ID_WIDTH-1:0] a,
                                    input logic [ID_WIDTH-1:0] b);
    logic [ID_WIDTH-1:0] diff;
    diff = a - b;
    return diff[ID_WIDTH-1];
  endfunction
`else
  logic [PORT_IDX_W-1:0] rr_q, rr_d;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < int'(NUM_PORTS); p++) state_q[p] <= IDLE;
      grant_q     <= '0;
      grant_alu_q <= '0;
      busy_q      <= '0;
      owner_q     <= '0;
`ifndef ALU_ARB_AGE_PRIORITY_EN
      rr_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_alu_q <= grant_alu_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
`ifndef ALU_ARB_AGE_PRIORITY_EN
      rr_q        <= rr_d;
`endif
    end
  end

  // Per-port transitions, releases, then ranked allocation over ALUs free at this edge
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_alu_d = grant_alu_q;
    busy_d      = busy_q;
    owner_d     = owner_q;
    elig        = '0;
    free_mask   = ~busy_q;
    found       = 1'b0;
    alu_found   = 1'b0;
    cand        = 0;
    alu_sel     = 0;
`ifdef ALU_ARB_AGE_PRIORITY_EN
    picked      = '0;
`else
    rr_d        = rr_q;
`endif

    if (bus.flush) begin
      for (int p = 0; p < int'(NUM_PORTS); p++) state_d[p] = IDLE;
      grant_d     = '0;
      grant_alu_d = '0;
      busy_d      = '0;
      owner_d     = '0;
    end else begin
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        unique case (state_q[p])
          IDLE: if (bus.req_valid[p]) state_d[p] = WAIT;
          WAIT: begin
            if (bus.req_valid[p]) elig[p] = 1'b1;
            else                  state_d[p] = IDLE;
          end
          OWN: begin
            if (bus.alu_release[p]) begin
              state_d[p]     = IDLE;
              grant_d[p]     = 1'b0;
              grant_alu_d[p] = '0;
              for (int a = 0; a < int'(NUM_ALUS); a++) begin
                if (ALU_IDX_W'(a) == grant_alu_q[p]) begin
                  busy_d[a]  = 1'b0;
                  owner_d[a] = '0;
                end
              end
            end
          end
          default: state_d[p] = IDLE;
        endcase
      end

      // Rank slot k picks a port, then takes the lowest-index ALU still free
      for (int k = 0; k < int'(NUM_PORTS); k++) begin
        found = 1'b0;
        cand  = 0;
`ifdef ALU_ARB_AGE_PRIORITY_EN
        for (int q = 0; q < int'(NUM_PORTS); q++) begin
          if (elig[q] && !picked[q] &&
              (!found || is_older(bus.req_id[q], bus.req_id[cand]))) begin
            cand  = q;
            found = 1'b1;
          end
        end
        if (found) picked[cand] = 1'b1;
`else
        cand  = (int'(rr_q) + k) % int'(NUM_PORTS);
        found = elig[cand];
`endif
        if (found) begin
          alu_found = 1'b0;
          alu_sel   = 0;
          for (int a = 0; a < int'(NUM_ALUS); a++) begin
            if (free_mask[a] && !alu_found) begin
              alu_sel   = a;
              alu_found = 1'b1;
            end
          end
          if (alu_found) begin
            free_mask[alu_sel] = 1'b0;
            state_d[cand]      = OWN;
            grant_d[cand]      = 1'b1;
            grant_alu_d[cand]  = ALU_IDX_W'(alu_sel);
            busy_d[alu_sel]    = 1'b1;
            owner_d[alu_sel]   = bus.req_id[cand];
`ifndef ALU_ARB_AGE_PRIORITY_EN
            rr_d = PORT_IDX_W'((cand + 1) % int'(NUM_PORTS));
`endif
          end
        end
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_alu = grant_alu_q;
  assign bus.alu_busy  = busy_q;
  assign bus.owner_id  = owner_q;

endmodule

// File: tb/tb_alu_pool_arbiter.sv
// Bench for alu_pool_arbiter: a 4-ALU and a 1-ALU instance, both 2 ports, checked against
// a queue-based reference model. Age-priority cases run when ALU_ARB_AGE_PRIORITY_EN is defined.
module tb_alu_pool_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_pool_arbiter_if #(.NUM_ALUS(4), .NUM_PORTS(2), .ID_WIDTH(16)) ifa ();
  alu_pool_arbiter_if #(.NUM_ALUS(1), .NUM_PORTS(2), .ID_WIDTH(16)) ifb ();

  alu_pool_arbiter #(.NUM_ALUS(4), .NUM_PORTS(2), .ID_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  alu_pool_arbiter #(.NUM_ALUS(1), .NUM_PORTS(2), .ID_WIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  // Stimulus per instance (index 0 -> dut_a, 1 -> dut_b)
  logic [1:0]  s_valid [2];
  logic [15:0] s_id    [2][2];
  logic [1:0]  s_rel   [2];
  logic        s_flush [2];

  assign ifa.req_valid   = s_valid[0];
  assign ifa.req_id      = {s_id[0][1], s_id[0][0]};
  assign ifa.alu_release = s_rel[0];
  assign ifa.flush       = s_flush[0];
  assign ifb.req_valid   = s_valid[1];
  assign ifb.req_id      = {s_id[1][1], s_id[1][0]};
  assign ifb.alu_release = s_rel[1];
  assign ifb.flush       = s_flush[1];

  // Reference model: 0 idle, 1 waiting, 2 owning
  int          m_st    [2][2];
  int          m_alu   [2][2];
  bit          m_busy  [2][4];
  logic [15:0] m_owner [2][4];
  int          m_rr    [2];

  int checks   = 0;
  int failures = 0;

  function automatic bit is_older(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] d;
    d = a - b;
    return d[15];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rr[i] = 0;
      for (int p = 0; p < 2; p++) begin m_st[i][p] = 0; m_alu[i][p] = 0; end
      for (int a = 0; a < 4; a++) begin m_busy[i][a] = 0; m_owner[i][a] = '0; end
    end
  endfunction

  function automatic void model_step(input int i);
    int n;
    int last;
    int ready[$];
    int ranked[$];
    int freeq[$];
    n = (i == 0) ? 4 : 1;
    if (s_flush[i]) begin
      for (int p = 0; p < 2; p++) m_st[i][p] = 0;
      for (int a = 0; a < 4; a++) begin m_busy[i][a] = 0; m_owner[i][a] = '0; end
      return;
    end
    for (int a = 0; a < n; a++) if (!m_busy[i][a]) freeq.push_back(a);
    for (int p = 0; p < 2; p++) begin
      case (m_st[i][p])
        0: if (s_valid[i][p]) m_st[i][p] = 1;
        1: if (s_valid[i][p]) ready.push_back(p); else m_st[i][p] = 0;
        default: if (s_rel[i][p]) begin
          m_busy[i][m_alu[i][p]]  = 0;
          m_owner[i][m_alu[i][p]] = '0;
          m_st[i][p] = 0;
        end
      endcase
    end
`ifdef ALU_ARB_AGE_PRIORITY_EN
    while (ready.size() > 0) begin
      int best;
      best = 0;
      for (int j = 1; j < ready.size(); j++)
        if (is_older(s_id[i][ready[j]], s_id[i][ready[best]])) best = j;
      ranked.push_back(ready[best]);
      ready.delete(best);
    end
`else
    for (int k = 0; k < 2; k++) begin
      int q;
      q = (m_rr[i] + k) % 2;
      foreach (ready[j]) if (ready[j] == q) ranked.push_back(q);
    end
`endif
    last = -1;
    for (int k = 0; k < ranked.size(); k++) begin
      if (k < freeq.size()) begin
        m_st[i][ranked[k]]     = 2;
        m_alu[i][ranked[k]]    = freeq[k];
        m_busy[i][freeq[k]]    = 1;
        m_owner[i][freeq[k]]   = s_id[i][ranked[k]];
        last = ranked[k];
      end
    end
    if (last >= 0) m_rr[i] = (last + 1) % 2;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int i);
    logic [1:0]  eg;
    logic [3:0]  eb;
    logic [63:0] eo;
    int n;
    n = (i == 0) ? 4 : 1;
    eg = '0; eb = '0; eo = '0;
    for (int p = 0; p < 2; p++) eg[p] = (m_st[i][p] == 2);
    for (int a = 0; a < n; a++) begin
      eb[a] = m_busy[i][a];
      eo[a*16 +: 16] = m_owner[i][a];
    end
    if (i == 0) begin
      check("dut_a grant", 64'(ifa.grant), 64'(eg));
      check("dut_a alu_busy", 64'(ifa.alu_busy), 64'(eb));
      check("dut_a owner_id", 64'(ifa.owner_id), eo);
      for (int p = 0; p < 2; p++)
        if (eg[p]) check("dut_a grant_alu", 64'(ifa.grant_alu[p]), 64'(m_alu[i][p]));
    end else begin
      check("dut_b grant", 64'(ifb.grant), 64'(eg));
      check("dut_b alu_busy", 64'(ifb.alu_busy), 64'(eb));
      check("dut_b owner_id", 64'(ifb.owner_id), eo);
      for (int p = 0; p < 2; p++)
        if (eg[p]) check("dut_b grant_alu", 64'(ifb.grant_alu[p]), 64'(m_alu[i][p]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    #1;
    check_all(0);
    check_all(1);
  endtask

  initial begin
    int seq[$];
    logic [1:0] prev_g, new_g, rel_now;

    for (int i = 0; i < 2; i++) begin
      s_valid[i] = '0; s_rel[i] = '0; s_flush[i] = 1'b0;
      s_id[i][0] = '0; s_id[i][1] = '0;
    end
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check_all(0);
    check_all(1);
    #10 rst_n = 1'b1;
    step();

    // Both ports request on the 4-ALU pool: ALUs 0 and 1, one cycle after sampling
    s_valid[0] = 2'b11;
    s_id[0][0] = 16'h0011;
    s_id[0][1] = 16'h0022;
    step();
    check("both_req no early grant", 64'(ifa.grant), 64'd0);
    step();
    check("both_req grant", 64'(ifa.grant), 64'b11);
    check("both_req grant_alu0", 64'(ifa.grant_alu[0]), 64'd0);
    check("both_req grant_alu1", 64'(ifa.grant_alu[1]), 64'd1);
    check("both_req alu_busy", 64'(ifa.alu_busy), 64'b0011);
    step();
    step();
    check("hold grant", 64'(ifa.grant), 64'b11);

    // Flush with both owning and port 1 releasing on the same edge
    s_flush[0] = 1'b1;
    s_rel[0]   = 2'b10;
    step();
    check("flush grant", 64'(ifa.grant), 64'd0);
    check("flush alu_busy", 64'(ifa.alu_busy), 64'd0);
    check("flush owner_id", 64'(ifa.owner_id), 64'd0);
    s_flush[0] = 1'b0;
    s_rel[0]   = 2'b00;
    step();
    step();
    s_valid[0] = 2'b00;
    s_rel[0]   = 2'b11;
    step();
    s_rel[0]   = 2'b00;
    step();

    // Single-ALU pool, continuous requests, release one cycle after each grant
    s_valid[1] = 2'b11;
    s_id[1][0] = 16'h0100;
    s_id[1][1] = 16'h0200;
    prev_g = '0;
    for (int c = 0; c < 16; c++) begin
      for (int p = 0; p < 2; p++) s_rel[1][p] = (m_st[1][p] == 2);
      rel_now = s_rel[1];
      step();
      if (rel_now != 2'b00) check("no same-cycle reuse", 64'(ifb.alu_busy), 64'd0);
      new_g = ifb.grant & ~prev_g;
      if (new_g[0]) seq.push_back(0);
      if (new_g[1]) seq.push_back(1);
      prev_g = ifb.grant;
    end
    check("alternation count", 64'(seq.size() >= 6), 64'd1);
    foreach (seq[k]) check("alternation order", 64'(seq[k]), 64'(k % 2));
    s_valid[1] = 2'b00;
    for (int p = 0; p < 2; p++) s_rel[1][p] = (m_st[1][p] == 2);
    step();
    s_rel[1] = 2'b00;
    step();

`ifdef ALU_ARB_AGE_PRIORITY_EN
    // Wrap-around age: 0xFFFE is older than 0x0001
    s_id[1][0] = 16'hFFFE;
    s_id[1][1] = 16'h0001;
    s_valid[1] = 2'b11;
    step();
    step();
    check("age wrap grant", 64'(ifb.grant), 64'b01);
    check("age wrap owner", 64'(ifb.owner_id), 64'hFFFE);
    s_valid[1] = 2'b00;
    s_rel[1]   = 2'b01;
    step();
    s_rel[1]   = 2'b00;
    step();
`endif

    // Randomized traffic on both pools
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 2; i++) begin
        s_valid[i] = 2'($urandom);
        s_rel[i]   = 2'($urandom);
        s_flush[i] = ($urandom_range(0, 19) == 0);
        for (int p = 0; p < 2; p++)
          if ($urandom_range(0, 3) == 0) s_id[i][p] = 16'($urandom);
          else if ($urandom_range(0, 3) == 0) s_id[i][p] = 16'hFFF0 + 16'($urandom_range(0, 31));
      end
      step();
    end

    // Asynchronous reset while owning, then a fresh request after release
    for (int i = 0; i < 2; i++) begin
      s_flush[i] = 1'b1; s_rel[i] = '0; s_valid[i] = '0;
    end
    step();
    s_flush[0] = 1'b0;
    s_flush[1] = 1'b0;
    s_valid[0] = 2'b11;
    step();
    step();
    check("pre-reset own", 64'(ifa.grant), 64'b11);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("async reset grant", 64'(ifa.grant), 64'd0);
    check("async reset alu_busy", 64'(ifa.alu_busy), 64'd0);
    check("async reset owner_id", 64'(ifa.owner_id), 64'd0);
    check("async reset grant_alu", 64'(ifa.grant_alu), 64'd0);
    step();
    s_valid[0] = 2'b01;
    #2 rst_n = 1'b1;
    step();
    check("post-reset latency", 64'(ifa.grant), 64'd0);
    step();
    check("post-reset grant", 64'(ifa.grant), 64'b01);
    check("post-reset alu", 64'(ifa.grant_alu[0]), 64'd0);
    s_valid[0] = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pool_arbiter.md
ALU_POOL_ARBITER -- requirements
Module: alu_pool_arbiter

Interface
REQ-001 SHALL have parameter NUM_ALUS, default 4, number of pooled ALUs.
REQ-002 SHALL have parameter NUM_PORTS, default 2, number of requesting SICs.
REQ-003 SHALL have parameter ID_WIDTH, default 16, issue-ID width.
REQ-004 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  [NUM_PORTS]  port requests an ALU lock.
REQ-007 SHALL have port req_id  input  [NUM_PORTS][ID_WIDTH]  issue ID of requesting instruction.
REQ-008 SHALL have port release  input  [NUM_PORTS]  pulse, owner returns its ALU.
REQ-009 SHALL have port flush  input  1  rollback, drop all locks.
REQ-010 SHALL have port grant  output  [NUM_PORTS]  level, port currently owns an ALU.
REQ-011 SHALL have port grant_alu  output  [NUM_PORTS][$clog2(NUM_ALUS)]  index of owned ALU, valid while grant.
REQ-012 SHALL have port alu_busy  output  [NUM_ALUS]  ALU locked mask.
REQ-013 SHALL have port owner_id  output  [NUM_ALUS][ID_WIDTH]  issue ID holding each busy ALU, 0 when free.

Function
REQ-014 SHALL keep per-port state IDLE, WAIT, OWN; IDLE->WAIT on req_valid; WAIT->OWN on grant; OWN->IDLE on release; WAIT->IDLE if req_valid drops before grant.
REQ-015 SHALL give each port at most one ALU; req_valid while OWN is ignored.
REQ-016 SHALL register grants: a request sampled at edge N yields grant high after edge N+1 at the earliest (1-cycle latency).
REQ-017 SHALL hold grant, grant_alu, owner_id stable from grant until release or flush.
REQ-018 SHALL, per cycle, rank WAIT ports by priority and give the k-th ranked port the k-th lowest-index free ALU; ports beyond free count stay WAIT.
REQ-019 SHALL use round-robin ranking from pointer rr_ptr; after a cycle with grants, rr_ptr = (last granted port + 1) mod NUM_PORTS; unchanged otherwise.
REQ-020 SHALL free an ALU at the edge sampling release; freed ALU is grantable no earlier than the following cycle (no same-cycle reuse).
REQ-021 SHALL ignore release from a port not in OWN.
REQ-022 SHALL, on flush, at the sampling edge clear all grant, alu_busy, owner_id, return every port to IDLE, and issue no new grant that edge; flush dominates simultaneous req_valid and release.
REQ-023 SHALL report owner_id and alu_busy as registered outputs consistent with grant every cycle.

Reset
REQ-024 SHALL, while rst_n low, force grant=0, grant_alu=0, alu_busy=0, owner_id=0, all ports IDLE, rr_ptr=0, regardless of clk.
REQ-025 SHALL abandon in-progress WAIT/OWN on reset mid-operation; first grant possible one edge after the first request sampled after rst_n rises.

Configuration
REQ-026 SHALL, with macro ALU_ARB_AGE_PRIORITY_EN defined, rank WAIT ports oldest-first by req_id: A older than B iff MSB of (A - B) mod 2^ID_WIDTH is 1; equal IDs ranked by lower port index; rr_ptr unused.
REQ-027 SHALL, without ALU_ARB_AGE_PRIORITY_EN, use round-robin ranking of REQ-019.

Verification
REQ-028 SHALL cover: NUM_ALUS=4, both ports req at cycle 0 -> grant[0]=grant[1]=1 at cycle 1, grant_alu 0 and 1, alu_busy=4'b0011.
REQ-029 SHALL cover: NUM_ALUS=1, ports 0,1 request continuously, each releases 1 cycle after grant, round-robin -> grants alternate 0,1,0,1; a released ALU never regranted in release cycle.
REQ-030 SHALL cover: age mode, req_id port0=16'hFFFE, port1=16'h0001, NUM_ALUS=1 -> port0 granted first (wrap-around older).
REQ-031 SHALL cover: flush with both ports OWN and port1 releasing same cycle -> next cycle grant=0, alu_busy=0, owner_id all 0, no grant that edge.
REQ-032 SHALL cover: rst_n low mid-OWN between edges -> outputs zero immediately, asynchronously; request after rst_n rises granted one edge later at ALU 0.
